// File: rtl/pll_ctrl_if.sv
// Control/status bundle between the PLL sequencer and its environment.
// The sequencer takes the slave view; whoever drives lock/restart takes master.
interface pll_ctrl_if;
  logic       i_pll_locked;
  logic       i_restart;
  logic       o_pll_resetb;
  logic       o_rst_n;
  logic       o_ready;
  logic       o_fail;
  logic [3:0] o_retry_cnt;
  logic [7:0] o_loss_cnt;
  logic [2:0] o_state;

  modport master (
    output i_pll_locked, i_restart,
    input  o_pll_resetb, o_rst_n, o_ready, o_fail, o_retry_cnt, o_loss_cnt, o_state
  );

  modport slave (
    input  i_pll_locked, i_restart,
    output o_pll_resetb, o_rst_n, o_ready, o_fail, o_retry_cnt, o_loss_cnt, o_state
  );
endinterface

// File: rtl/pll_ctrl.sv
// PLL bring-up sequencer: holds the PLL in reset, waits for a stable lock,
// releases downstream reset, and retries on timeout up to a fixed budget.
module pll_ctrl #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned LOCK_CYCLES    = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  pll_ctrl_if.slave bus
);

  localparam int unsigned RST_W  = (RST_CYCLES     > 1) ? $clog2(RST_CYCLES)     : 1;
  localparam int unsigned STAB_W = (LOCK_CYCLES    > 1) ? $clog2(LOCK_CYCLES)    : 1;
  localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic              lock_meta, lock_sync;
  logic [RST_W-1:0]  rst_cnt, rst_cnt_nx;
  logic [STAB_W-1:0] stab_cnt, stab_cnt_nx;
  logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_nx;
  logic [3:0]        retry_cnt, retry_cnt_nx, retry_inc;
  logic [7:0]        loss_cnt, loss_cnt_nx;
  logic              timeout, stable_done;
  logic              pll_resetb_q, rst_n_q, ready_q, fail_q;

  assign timeout     = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign stable_done = lock_sync && (stab_cnt == STAB_W'(LOCK_CYCLES - 1));
  assign retry_inc   = retry_cnt + 4'd1;

  always_comb begin
    state_nx     = state;
    rst_cnt_nx   = rst_cnt;
    stab_cnt_nx  = stab_cnt;
    tmo_cnt_nx   = tmo_cnt;
    retry_cnt_nx = retry_cnt;
    loss_cnt_nx  = loss_cnt;

    if (bus.i_restart) begin
      state_nx     = ST_RESET;
      rst_cnt_nx   = '0;
      retry_cnt_nx = '0;
    end else begin
      unique case (state)
        ST_RESET: begin
          if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
            state_nx   = ST_WAIT_LOCK;
            tmo_cnt_nx = '0;
          end else begin
            rst_cnt_nx = rst_cnt + RST_W'(1);
          end
        end
        ST_WAIT_LOCK, ST_STABLE: begin
          // Completion outranks timeout; timeout outranks a lock drop.
          if (state == ST_STABLE && stable_done) begin
            state_nx = ST_RUN;
          end else if (timeout) begin
            retry_cnt_nx = retry_inc;
            rst_cnt_nx   = '0;
            state_nx     = (retry_inc == 4'(MAX_RETRY)) ? ST_FAIL : ST_RESET;
          end else begin
            tmo_cnt_nx = tmo_cnt + TMO_W'(1);
            if (!lock_sync) begin
              state_nx = ST_WAIT_LOCK;
            end else if (state == ST_WAIT_LOCK) begin
              state_nx    = ST_STABLE;
              stab_cnt_nx = '0;
            end else begin
              stab_cnt_nx = stab_cnt + STAB_W'(1);
            end
          end
        end
        ST_RUN: begin
          if (!lock_sync) begin
            state_nx   = ST_RESET;
            rst_cnt_nx = '0;
            if (loss_cnt != 8'hFF) loss_cnt_nx = loss_cnt + 8'd1;
          end
        end
        ST_FAIL: ;
        default: state_nx = ST_RESET;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= ST_RESET;
      lock_meta    <= 1'b0;
      lock_sync    <= 1'b0;
      rst_cnt      <= '0;
      stab_cnt     <= '0;
      tmo_cnt      <= '0;
      retry_cnt    <= '0;
      loss_cnt     <= '0;
      pll_resetb_q <= 1'b0;
      rst_n_q      <= 1'b0;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state        <= state_nx;
      lock_meta    <= bus.i_pll_locked;
      lock_sync    <= lock_meta;
      rst_cnt      <= rst_cnt_nx;
      stab_cnt     <= stab_cnt_nx;
      tmo_cnt      <= tmo_cnt_nx;
      retry_cnt    <= retry_cnt_nx;
      loss_cnt     <= loss_cnt_nx;
      // Flags are decoded from the next state so they track the state register exactly.
      pll_resetb_q <= (state_nx != ST_RESET) && (state_nx != ST_FAIL);
      rst_n_q      <= (state_nx == ST_RUN);
      ready_q      <= (state_nx == ST_RUN);
      fail_q       <= (state_nx == ST_FAIL);
    end
  end

  assign bus.o_state      = state;
  assign bus.o_pll_resetb = pll_resetb_q;
  assign bus.o_rst_n      = rst_n_q;
  assign bus.o_ready      = ready_q;
  assign bus.o_fail       = fail_q;
  assign bus.o_retry_cnt  = retry_cnt;
  assign bus.o_loss_cnt   = loss_cnt;

endmodule
